// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NREQ requesters. Requests are served
// round-robin, one frame per grant. TxEn is held until the transmitter reports
// TxDone. An optional watchdog aborts a frame whose TxDone never arrives.
// A one-cycle GAP after every frame guarantees the transmitter sees TxEn low
// between frames.
//
// Parameters
//   NREQ     number of requesters (2..16)
//   DW       data word width, matches the transmitter's TxData width
//   TIMEOUT  max cycles in SEND waiting for TxDone; 0 disables the watchdog
//
// Ports
//   Clk      in   system clock, all logic on posedge
//   Rst_n    in   asynchronous active-low reset
//   Req      in   level request per requester, held until its Gnt pulse
//   ReqData  in   packed words, requester i at [i*DW +: DW]
//   Gnt      out  one-hot single-cycle pulse when a word is latched
//   Owner    out  one-hot id of the current frame owner during SEND, else 0
//   Busy     out  high in SEND and GAP
//   TxEn     out  transmit enable to the UART, high only in SEND
//   TxData   out  registered word, stable for the whole of SEND
//   TxDone   in   one-cycle end-of-frame pulse from the UART
//   Timeout  out  one-cycle pulse when the watchdog aborts a frame
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [NREQ-1:0]    Req,
    input  logic [NREQ*DW-1:0] ReqData,
    output logic [NREQ-1:0]    Gnt,
    output logic [NREQ-1:0]    Owner,
    output logic               Busy,
    output logic               TxEn,
    output logic [DW-1:0]      TxData,
    input  logic               TxDone,
    output logic               Timeout
);

    localparam int IW = $clog2(NREQ);
    // A disabled watchdog still needs a one-bit timer so the logic stays legal.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   last;
    logic [IW-1:0]   last_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic [NREQ-1:0] gnt_next;
    logic [NREQ-1:0] owner_next;
    logic            busy_next;
    logic            txen_next;
    logic [DW-1:0]   txdata_next;
    logic            timeout_next;

    logic            found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic [DW-1:0]   win_data;
    int              cand;

    // Round-robin search: start just after the previous winner and take the
    // first requester whose bit is set, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last) + i) % NREQ;
            if (!found && Req[cand]) begin
                found   = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
        win_onehot = NREQ'(1) << win_idx;
        win_data   = ReqData[int'(win_idx)*DW +: DW];
    end

    // Next-state and next-output logic. Every output is registered so the
    // transmitter sees clean levels; values default to holding their state,
    // while the Gnt and Timeout pulses default to low.
    always_comb begin
        state_next   = state;
        last_next    = last;
        timer_next   = timer;
        gnt_next     = '0;
        owner_next   = Owner;
        busy_next    = Busy;
        txen_next    = TxEn;
        txdata_next  = TxData;
        timeout_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    txdata_next = win_data;
                    owner_next  = win_onehot;
                    gnt_next    = win_onehot;
                    txen_next   = 1'b1;
                    busy_next   = 1'b1;
                    last_next   = win_idx;
                    timer_next  = '0;
                    state_next  = SEND;
                end
            end

            SEND: begin
                // Saturating so a disabled watchdog never wraps.
                if (timer != {TW{1'b1}}) begin
                    timer_next = timer + 1'b1;
                end
                // TxDone is checked first so it wins over a same-cycle expiry.
                if (TxDone) begin
                    txen_next  = 1'b0;
                    owner_next = '0;
                    state_next = GAP;
                end else if ((TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1))) begin
                    txen_next    = 1'b0;
                    owner_next   = '0;
                    timeout_next = 1'b1;
                    state_next   = GAP;
                end
            end

            GAP: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                txen_next  = 1'b0;
                owner_next = '0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. The pointer resets to NREQ-1 so that
    // requester 0 has first priority after reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            last    <= IW'(NREQ - 1);
            timer   <= '0;
            Gnt     <= '0;
            Owner   <= '0;
            Busy    <= 1'b0;
            TxEn    <= 1'b0;
            TxData  <= '0;
            Timeout <= 1'b0;
        end else begin
            state   <= state_next;
            last    <= last_next;
            timer   <= timer_next;
            Gnt     <= gnt_next;
            Owner   <= owner_next;
            Busy    <= busy_next;
            TxEn    <= txen_next;
            TxData  <= txdata_next;
            Timeout <= timeout_next;
        end
    end

endmodule
